// File: rtl/mux_scan_bus.sv
// mux_scan_bus: N-channel, W-bit bus multiplexer with a registered output.
// Manual mode picks a channel with i_sel. Auto-scan mode steps an internal pointer
// through the channels, dwelling DWELL cycles on each one.
// Optional feature: define MUX_SCAN_MASK_EN to add i_ch_mask (1 = channel enabled).
// With the mask, scanning skips disabled channels, and selecting a disabled channel
// counts as an invalid select.
module mux_scan_bus #(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned DWELL    = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [CHANNELS*WIDTH-1:0] i_in,
    input  logic [SEL_W-1:0]          i_sel,
    input  logic                      i_mode,
    input  logic                      i_hold,
`ifdef MUX_SCAN_MASK_EN
    input  logic [CHANNELS-1:0]       i_ch_mask,
`endif
    output logic [WIDTH-1:0]          o_out,
    output logic [SEL_W-1:0]          o_out_ch,
    output logic                      o_valid,
    output logic                      o_err,
    output logic                      o_frame
);

    localparam int unsigned      CNT_W    = $clog2(DWELL) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [WIDTH-1:0] r_out;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_valid;
    logic             r_err;
    logic             r_frame;
    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;

    logic [CHANNELS-1:0] w_en;
    logic                w_any_en;
    logic                w_sel_ok;
    logic [SEL_W-1:0]    w_first_en;
    logic [SEL_W-1:0]    w_ptr_adv;
    logic                w_step;
    logic [SEL_W-1:0]    w_ptr_nxt;
    logic [SEL_W-1:0]    w_entry_ptr;

`ifdef MUX_SCAN_MASK_EN
    assign w_en = i_ch_mask;
`else
    assign w_en = '1;
`endif

    // Channel data for index idx; out-of-range indices read as zero.
    function automatic logic [WIDTH-1:0] f_pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                                input logic [SEL_W-1:0]          idx);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (idx == SEL_W'(i)) v = bus[i*WIDTH +: WIDTH];
        end
        return v;
    endfunction

    // Select validation, lowest enabled channel and next enabled channel after r_ptr.
    always_comb begin
        w_any_en   = |w_en;
        w_sel_ok   = 1'b0;
        w_first_en = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (i_sel == SEL_W'(i)) w_sel_ok = w_en[i];
        end
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (w_en[i]) w_first_en = SEL_W'(i);
        end
        // Smallest enabled index above r_ptr, else wrap to the lowest enabled one.
        w_ptr_adv = w_first_en;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (w_en[i] && (SEL_W'(i) > r_ptr)) w_ptr_adv = SEL_W'(i);
        end
        w_step      = (r_cnt == CNT_LAST);
        // The output follows the pointer on the advance edge, so each channel
        // stays on o_out_ch for exactly DWELL cycles.
        w_ptr_nxt   = w_step ? w_ptr_adv : r_ptr;
        w_entry_ptr = w_sel_ok ? i_sel : w_first_en;
    end

    // Output, pointer, dwell counter and mode history; reset wins, then hold, then mode.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out    <= '0;
            r_out_ch <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_frame  <= 1'b0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_mode   <= 1'b0;
        end else begin
            r_err   <= 1'b0;
            r_frame <= 1'b0;
            if (i_hold) begin
                // All state frozen; the pulses above are cleared.
            end else if (!i_mode) begin
                r_mode <= 1'b0;
                if (w_sel_ok) begin
                    r_out    <= f_pick(i_in, i_sel);
                    r_out_ch <= i_sel;
                    r_valid  <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (!w_any_en) begin
                // Nothing to scan: keep everything and flag every cycle.
                r_err <= 1'b1;
            end else if (!r_mode) begin
                r_mode   <= 1'b1;
                r_ptr    <= w_entry_ptr;
                r_cnt    <= '0;
                r_out    <= f_pick(i_in, w_entry_ptr);
                r_out_ch <= w_entry_ptr;
                r_valid  <= 1'b1;
                r_err    <= !w_sel_ok;
            end else begin
                r_cnt    <= w_step ? '0 : r_cnt + CNT_W'(1);
                r_ptr    <= w_ptr_nxt;
                r_out    <= f_pick(i_in, w_ptr_nxt);
                r_out_ch <= w_ptr_nxt;
                r_frame  <= w_step && (w_ptr_adv < r_ptr);
            end
        end
    end

    assign o_out    = r_out;
    assign o_out_ch = r_out_ch;
    assign o_valid  = r_valid;
    assign o_err    = r_err;
    assign o_frame  = r_frame;

endmodule

// File: doc/mux_scan_bus.md
Name: mux_scan_bus

Overview:
- Parametrised N-channel, W-bit bus multiplexer with a registered output.
- Manual mode: a select input picks the channel.
- Auto-scan mode: an internal pointer steps through all channels, staying on each one for a programmable number of cycles (the dwell).
- Feeds the display/sampling path that time-shares one W-bit bus across several sources.

Parameters:
- CHANNELS, 8, number of input channels (2..16).
- WIDTH, 4, bits per channel.
- SEL_W, 4, width of sel and out_ch; must satisfy 2^SEL_W >= CHANNELS.
- DWELL, 4, cycles spent on each channel in scan mode (>= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- in  input  CHANNELS*WIDTH  packed channels; channel i = in[i*WIDTH +: WIDTH].
- sel  input  SEL_W  manual channel select; also the scan start channel.
- mode  input  1  0 = manual, 1 = auto-scan.
- hold  input  1  freeze all state while high.
- out  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  channel index that produced out.
- valid  output  1  out holds data sampled since reset.
- err  output  1  one-cycle pulse: invalid select was rejected.
- frame  output  1  one-cycle pulse: scan pointer wrapped to channel 0.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset (has priority over everything else): out=0, out_ch=0, valid=0, err=0, frame=0. Internal ptr=0, dwell counter cnt=0, stored mode_q=0.
- Priority after reset: hold, then mode-entry reload, then normal operation.
- hold=1: out, out_ch, valid, ptr, cnt and mode_q are all frozen; err and frame are driven to 0.
- Manual mode (mode=1'b0), sel < CHANNELS:
  - out <= in[sel], out_ch <= sel, valid <= 1.
  - Latency is 1 cycle from sel/in to out.
- Manual mode, sel >= CHANNELS:
  - out, out_ch and valid hold their values; err <= 1 for that cycle.
  - err re-pulses on every cycle that the invalid sel persists.
- Scan entry (mode rises 0 -> 1 as seen against mode_q):
  - ptr <= sel if sel < CHANNELS, else ptr <= 0 and err <= 1.
  - cnt <= 0; out <= in[new ptr]; out_ch <= new ptr; valid <= 1.
- Scan steady state (mode=1, mode_q=1):
  - Every cycle: out <= in[ptr], out_ch <= ptr, so live input changes propagate.
  - If cnt == DWELL-1: cnt <= 0 and ptr advances. If ptr == CHANNELS-1 it wraps to 0 and frame <= 1 that same cycle.
  - Otherwise cnt <= cnt+1.
  - Result: each channel is visible on out_ch for exactly DWELL cycles.
- Scan exit (mode falls 1 -> 0): manual rules apply immediately; ptr and cnt are retained but not used.
- DWELL=1: the pointer advances every cycle.
- Internal counters: ptr is SEL_W bits; cnt is clog2(DWELL)+1 bits. Neither may overflow.
- Reset mid-scan: the next cycle shows the reset values; scan resumes through the normal entry path once mode_q is seen as 0.

Optional Feature:
- Macro: MUX_SCAN_MASK_EN.
- Defined:
  - Adds port ch_mask (input, CHANNELS bits; 1 = channel enabled).
  - Scan advance skips disabled channels by stepping to the next enabled index, with wrap.
  - frame pulses when the pointer moves from a higher index to a lower index.
  - Manual select or scan entry onto a disabled channel is treated as an invalid select.
  - If ch_mask is all zero: out holds and err pulses every cycle.
- Undefined: no ch_mask port; all channels are enabled; behaviour exactly as above.

Test Plan:
- Setup: CHANNELS=8, WIDTH=4, DWELL=4; channels 0..7 = 12,15,1,3,5,2,11,14.
- Manual select: mode=0, sel=3,5,7,0,2, one cycle each -> out = 3,2,14,12,1 one cycle after each sel; out_ch follows sel; err stays 0.
- Invalid select: mode=0, sel=2 then sel=9 for 2 cycles -> out stays 1, out_ch stays 2, err=1 on both cycles; valid stays 1.
- Scan with wrap: sel=6, then mode=1 -> out=11 for 4 cycles, then 14 for 4 cycles, then 12 with frame=1 on the cycle out_ch becomes 0.
- Hold mid-scan: during scan, hold=1 for 3 cycles -> out, out_ch and cnt are frozen and frame=0; after release the remaining dwell completes unchanged.
- Reset mid-scan: reset=1 for 1 cycle at out_ch=5 -> next cycle out=0, out_ch=0, valid=0; with mode still 1, scan restarts from sel.
- Mask (MUX_SCAN_MASK_EN defined): ch_mask=8'b1010_0101, scan from 0 -> out_ch sequence 0,2,5,7,0; frame=1 on the 7 -> 0 step.
